// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the iterative signed multiply/divide unit.
package multdiv_pkg;
    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_DONE
    } state_t;

    // Two's complement magnitude; 0x80000000 maps to itself as an unsigned value.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction
endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: cleared on the start edge, counts while enabled, flags the last iteration.
module multdiv_counter
    import multdiv_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    always_ff @(posedge clk) begin
        if (!clr_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

    assign tc = (cnt == CNT_W'(ITER - 1));
endmodule

// File: rtl/multdiv_unit.sv
// Signed 32-bit multiply (shift-add) and divide (restoring), one iteration per cycle.
module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    state_t                 state;
    logic [2*WIDTH-1:0]     acc;
    logic [WIDTH-1:0]       opnd;
    logic                   neg;
    logic                   is_div;
    logic                   div_zero;

    logic [CNT_W-1:0]       cnt;
    logic                   tc;
    logic                   start_mul, start_div, accept;

    assign start_mul = (state == ST_IDLE) && ctrl_MULT && !ctrl_DIV;
    assign start_div = (state == ST_IDLE) && ctrl_DIV && !ctrl_MULT;
    assign accept    = start_mul || start_div;

    multdiv_counter u_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .clr   (accept),
        .en    ((state == ST_MULT) || (state == ST_DIV)),
        .cnt   (cnt),
        .tc    (tc)
    );

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Restoring step: acc = {remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0]   div_sh;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    assign div_sh   = {acc[2*WIDTH-2:0], 1'b0};
    assign div_diff = {1'b0, div_sh[2*WIDTH-1:WIDTH]} - {1'b0, opnd};
    assign div_next = div_diff[WIDTH] ? div_sh
                                      : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

    logic [2*WIDTH-1:0]   prod_s;
    logic                 mul_exc;
    logic [WIDTH-1:0]     quot_s;
    logic                 div_exc;
    assign prod_s  = neg ? (~acc + (2*WIDTH)'(1)) : acc;
    assign mul_exc = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
    assign quot_s  = neg ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    // A positive quotient with the top bit set cannot be represented (min_int / -1).
    assign div_exc = acc[WIDTH-1] && !neg;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state          <= ST_IDLE;
            acc            <= '0;
            opnd           <= '0;
            neg            <= 1'b0;
            is_div         <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (data_resultRDY)
                busy <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        busy     <= 1'b1;
                        neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        is_div   <= start_div;
                        div_zero <= start_div && (data_operandB == '0);
                        if (start_mul) begin
                            acc   <= {{WIDTH{1'b0}}, mag(data_operandB)};
                            opnd  <= mag(data_operandA);
                            state <= ST_MULT;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, mag(data_operandA)};
                            opnd  <= mag(data_operandB);
                            state <= (data_operandB == '0) ? ST_DONE : ST_DIV;
                        end
                    end
                end
                ST_MULT: begin
                    acc <= mul_next;
                    if (tc)
                        state <= ST_DONE;
                end
                ST_DIV: begin
                    acc <= div_next;
                    if (tc)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (div_zero) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                    end else if (is_div) begin
                        data_result    <= quot_s;
                        data_exception <= div_exc;
                    end else begin
                        data_result    <= prod_s[WIDTH-1:0];
                        data_exception <= mul_exc;
                    end
                    data_resultRDY <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, results, exceptions, ignored starts, reset abort.
module tb_multdiv_unit;
    logic        clk = 1'b0;
    logic        clr_n;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int errors = 0;
    int checks = 0;

    multdiv_unit dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble the operand inputs afterwards, and return cycles to RDY (0 = timeout).
    task automatic run_op(input logic mul, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        data_operandA = a; data_operandB = b;
        ctrl_MULT = mul; ctrl_DIV = !mul;
        tick();
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = 32'hDEAD_BEEF; data_operandB = 32'h0;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        tick(); tick();
        checks += 4;
        if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", data_result); end
        if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got=%b exp=0", data_exception); end
        if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", data_resultRDY); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        clr_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int lat;
        run_op(1'b1, 32'd7, -32'sd6, lat);
        checks += 4;
        if (lat !== 33) begin errors++; $display("FAIL mult_lat got=%0d exp=33", lat); end
        if (data_result !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mult_res got=%h exp=ffffffd6", data_result); end
        if (data_exception !== 1'b0) begin errors++; $display("FAIL mult_exc got=%b exp=0", data_exception); end
        if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_at_rdy got=%b exp=1", busy); end
        tick();
        checks += 3;
        if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL mult_rdy_width got=%b exp=0", data_resultRDY); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_after got=%b exp=0", busy); end
        if (data_result !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mult_hold got=%h exp=ffffffd6", data_result); end
    endtask

    task automatic test_mult_overflow();
        int lat;
        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, lat);
        checks += 3;
        if (lat !== 33) begin errors++; $display("FAIL movf_lat got=%0d exp=33", lat); end
        if (data_result !== 32'h0) begin errors++; $display("FAIL movf_res got=%h exp=0", data_result); end
        if (data_exception !== 1'b1) begin errors++; $display("FAIL movf_exc got=%b exp=1", data_exception); end
        tick();
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001, lat);
        checks += 2;
        if (data_result !== 32'h8000_0000) begin errors++; $display("FAIL mmin_res got=%h exp=80000000", data_result); end
        if (data_exception !== 1'b0) begin errors++; $display("FAIL mmin_exc got=%b exp=0", data_exception); end
        tick();
    endtask

    task automatic test_div();
        int lat;
        run_op(1'b0, -32'sd17, 32'd5, lat);
        checks += 3;
        if (lat !== 33) begin errors++; $display("FAIL div_lat got=%0d exp=33", lat); end
        if (data_result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_res got=%h exp=fffffffd", data_result); end
        if (data_exception !== 1'b0) begin errors++; $display("FAIL div_exc got=%b exp=0", data_exception); end
        tick();
        run_op(1'b0, 32'd5, 32'd0, lat);
        checks += 3;
        if (lat !== 1) begin errors++; $display("FAIL dz_lat got=%0d exp=1", lat); end
        if (data_result !== 32'h0) begin errors++; $display("FAIL dz_res got=%h exp=0", data_result); end
        if (data_exception !== 1'b1) begin errors++; $display("FAIL dz_exc got=%b exp=1", data_exception); end
        tick();
    endtask

    task automatic test_div_overflow();
        int lat;
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks += 3;
        if (lat !== 33) begin errors++; $display("FAIL dovf_lat got=%0d exp=33", lat); end
        if (data_result !== 32'h8000_0000) begin errors++; $display("FAIL dovf_res got=%h exp=80000000", data_result); end
        if (data_exception !== 1'b1) begin errors++; $display("FAIL dovf_exc got=%b exp=1", data_exception); end
        tick();
        run_op(1'b0, 32'd100, -32'sd7, lat);
        checks += 2;
        if (data_result !== 32'hFFFF_FFF2) begin errors++; $display("FAIL dneg_res got=%h exp=fffffff2", data_result); end
        if (data_exception !== 1'b0) begin errors++; $display("FAIL dneg_exc got=%b exp=0", data_exception); end
        tick();
    endtask

    task automatic test_ignored_starts();
        int lat = 0;
        int rdy_cnt = 0;
        data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 10) begin
                ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd3;
            end
            tick();
            ctrl_MULT = 1'b0;
            if (data_resultRDY) begin lat = n; break; end
        end
        checks += 2;
        if (lat !== 33) begin errors++; $display("FAIL ign_mid_lat got=%0d exp=33", lat); end
        if (data_result !== 32'd14) begin errors++; $display("FAIL ign_mid_res got=%h exp=0000000e", data_result); end
        tick();
        ctrl_MULT = 1'b1; ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
        tick();
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        checks += 1;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_both_busy got=%b exp=0", busy); end
        for (int n = 0; n < 40; n++) begin
            tick();
            if (data_resultRDY) rdy_cnt++;
        end
        checks += 2;
        if (rdy_cnt !== 0) begin errors++; $display("FAIL ign_both_rdy got=%0d exp=0", rdy_cnt); end
        if (data_result !== 32'd14) begin errors++; $display("FAIL ign_both_hold got=%h exp=0000000e", data_result); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int rdy_cnt = 0;
        data_operandA = 32'h0000_1234; data_operandB = 32'h0000_5678; ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        clr_n = 1'b0; ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        checks += 3;
        if (data_result !== 32'h0) begin errors++; $display("FAIL abort_res got=%h exp=0", data_result); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (data_exception !== 1'b0) begin errors++; $display("FAIL abort_exc got=%b exp=0", data_exception); end
        clr_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (data_resultRDY) rdy_cnt++;
        end
        checks += 1;
        if (rdy_cnt !== 0) begin errors++; $display("FAIL abort_rdy got=%0d exp=0", rdy_cnt); end
        run_op(1'b1, 32'd3, 32'd4, lat);
        checks += 2;
        if (lat !== 33) begin errors++; $display("FAIL post_abort_lat got=%0d exp=33", lat); end
        if (data_result !== 32'd12) begin errors++; $display("FAIL post_abort_res got=%h exp=0000000c", data_result); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        int lat2 = 0;
        run_op(1'b1, -32'sd3, -32'sd5, lat);
        checks += 2;
        if (lat !== 33) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=33", lat); end
        if (data_result !== 32'd15) begin errors++; $display("FAIL b2b_res1 got=%h exp=0000000f", data_result); end
        // Issue immediately in the RDY cycle: the unit is already back in IDLE.
        data_operandA = 32'd1000; data_operandB = -32'sd10; ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        checks += 1;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 20) begin
                checks += 1;
                if (data_result !== 32'd15) begin errors++; $display("FAIL b2b_hold got=%h exp=0000000f", data_result); end
            end
            if (data_resultRDY) begin lat2 = n; break; end
        end
        checks += 2;
        if (lat2 !== 33) begin errors++; $display("FAIL b2b_lat2 got=%0d exp=33", lat2); end
        if (data_result !== 32'hFFFF_FF9C) begin errors++; $display("FAIL b2b_res2 got=%h exp=ffffff9c", data_result); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_mult_overflow();
        test_div();
        test_div_overflow();
        test_ignored_starts();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
